// File: rtl/seg_score_reader_pkg.sv
// Shared constants for the seven-segment score reader: digit geometry, the
// active-low segment patterns for 0..9, the FSM state type and a BCD compare.
package score_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned SEG_W      = 7;

    // Active-low patterns, bit 6 = segment g
    localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h18;

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        CAPTURE = 2'd1,
        COMPARE = 2'd2
    } state_t;

    // Unsigned BCD magnitude compare, most significant digit decides first.
    function automatic logic bcd_gt(input logic [NUM_DIGITS*DIGIT_W-1:0] a,
                                    input logic [NUM_DIGITS*DIGIT_W-1:0] b);
        logic decided;
        logic gt;
        decided = 1'b0;
        gt      = 1'b0;
        for (int unsigned i = NUM_DIGITS; i > 0; i--) begin
            if (!decided && (a[(i-1)*DIGIT_W +: DIGIT_W] != b[(i-1)*DIGIT_W +: DIGIT_W])) begin
                decided = 1'b1;
                gt      = (a[(i-1)*DIGIT_W +: DIGIT_W] > b[(i-1)*DIGIT_W +: DIGIT_W]);
            end
        end
        return gt;
    endfunction

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational decode of one active-low seven-segment pattern to a BCD digit;
// anything outside the ten decimal patterns (blank, A-F, junk) is invalid.
module seg_to_bcd
    import score_pkg::*;
(
    input  logic [SEG_W-1:0]   seg,
    output logic [DIGIT_W-1:0] digit,
    output logic               valid
);

    always_comb begin
        digit = '0;
        valid = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_score_reader.sv
// Reads a six-digit seven-segment score display, captures each stable word once,
// and (with SEG_SCORE_READER_HIGH_EN defined) tracks the highest score seen.
module seg_score_reader
    import score_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  hex0,
    input  logic [6:0]  hex1,
    input  logic [6:0]  hex2,
    input  logic [6:0]  hex3,
    input  logic [6:0]  hex4,
    input  logic [6:0]  hex5,
    input  logic        clear_high,
    output logic [23:0] score_bcd,
    output logic        score_valid,
    output logic        decode_err,
    output logic [23:0] high_bcd,
    output logic        new_high
);

    localparam int unsigned WORD_W  = NUM_DIGITS * SEG_W;
    localparam int unsigned BCD_W   = NUM_DIGITS * DIGIT_W;
    localparam logic [7:0]  CNT_MAX = 8'(STABLE_CYCLES - 1);

    logic [WORD_W-1:0]     word;
    logic [WORD_W-1:0]     prev_q;
    logic [7:0]            cnt_q, cnt_d;
    logic                  armed_q, armed_d;
    state_t                state_q, state_d;
    logic [BCD_W-1:0]      score_q, score_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [BCD_W-1:0]      dec_bcd;
    logic [NUM_DIGITS-1:0] dig_ok;
    logic                  same;
    logic                  trigger;

    assign word = {hex5, hex4, hex3, hex2, hex1, hex0};

    // Decode the registered sample, which still holds the stable word in CAPTURE
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
        seg_to_bcd u_dec (
            .seg   (prev_q[i*SEG_W +: SEG_W]),
            .digit (dec_bcd[i*DIGIT_W +: DIGIT_W]),
            .valid (dig_ok[i])
        );
    end

    always_comb begin
        same    = (word == prev_q);
        cnt_d   = '0;
        if (same) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : 8'(cnt_q + 8'd1);
        end
        // Fires on the edge where the counter reaches its limit, so a capture
        // result appears STABLE_CYCLES edges after the word changed.
        trigger = (state_q == WAIT) && armed_q && same && (cnt_d == CNT_MAX);
        armed_d = !same ? 1'b1 : (trigger ? 1'b0 : armed_q);

        state_d = state_q;
        score_d = score_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            WAIT: begin
                if (trigger) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (&dig_ok) begin
                    score_d = dec_bcd;
                    valid_d = 1'b1;
`ifdef SEG_SCORE_READER_HIGH_EN
                    state_d = COMPARE;
`else
                    state_d = WAIT;
`endif
                end else begin
                    err_d   = 1'b1;
                    state_d = WAIT;
                end
            end
            COMPARE: state_d = WAIT;
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= '1;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            state_q <= WAIT;
            score_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            prev_q  <= word;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            state_q <= state_d;
            score_q <= score_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign score_bcd   = score_q;
    assign score_valid = valid_q;
    assign decode_err  = err_q;

`ifdef SEG_SCORE_READER_HIGH_EN
    logic [BCD_W-1:0] high_q, high_d;
    logic             nh_q, nh_d;

    always_comb begin
        high_d = high_q;
        nh_d   = 1'b0;
        if (clear_high) begin
            high_d = '0;
        end else if ((state_q == COMPARE) && bcd_gt(score_q, high_q)) begin
            high_d = score_q;
            nh_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            high_q <= '0;
            nh_q   <= 1'b0;
        end else begin
            high_q <= high_d;
            nh_q   <= nh_d;
        end
    end

    assign high_bcd = high_q;
    assign new_high = nh_q;
`else
    logic unused_clear;
    assign unused_clear = clear_high;
    assign high_bcd     = '0;
    assign new_high     = 1'b0;
`endif

endmodule

// File: tb/tb_seg_score_reader.sv
// Scoreboard bench for seg_score_reader: stimulus pushes expected pulses, a
// negedge monitor pops and compares them against what the DUT presents.
module tb_seg_score_reader;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  hex0 = 7'h7F, hex1 = 7'h7F, hex2 = 7'h7F;
    logic [6:0]  hex3 = 7'h7F, hex4 = 7'h7F, hex5 = 7'h7F;
    logic        clear_high = 1'b0;
    logic [23:0] score_bcd, high_bcd;
    logic        score_valid, decode_err, new_high;

    seg_score_reader #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .hex0        (hex0),
        .hex1        (hex1),
        .hex2        (hex2),
        .hex3        (hex3),
        .hex4        (hex4),
        .hex5        (hex5),
        .clear_high  (clear_high),
        .score_bcd   (score_bcd),
        .score_valid (score_valid),
        .decode_err  (decode_err),
        .high_bcd    (high_bcd),
        .new_high    (new_high)
    );

    always #5 clk = ~clk;

`ifdef SEG_SCORE_READER_HIGH_EN
    localparam bit HIGH_EN = 1'b1;
`else
    localparam bit HIGH_EN = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = score_valid, 1 = decode_err, 2 = new_high
    typedef struct {
        int          kind;
        logic [23:0] val;
        int          at;
    } ev_t;
    ev_t q[$];

    logic [6:0]  pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h18};
    string       kname [3] = '{"score_valid", "decode_err", "new_high"};
    logic [23:0] score_m  = '0;
    logic [23:0] high_m   = '0;
    int          high_num = 0;
    logic [41:0] last_w   = '1;

    function automatic logic [41:0] word_of(input int v);
        logic [41:0] w;
        int          t;
        t = v;
        for (int i = 0; i < 6; i++) begin
            w[7*i +: 7] = pat[t % 10];
            t = t / 10;
        end
        return w;
    endfunction

    function automatic bit dec_word(input logic [41:0] w, output logic [23:0] bcd, output int num);
        bit ok;
        int mul;
        int found;
        ok  = 1'b1;
        bcd = '0;
        num = 0;
        mul = 1;
        for (int i = 0; i < 6; i++) begin
            found = -1;
            for (int d = 0; d < 10; d++)
                if (w[7*i +: 7] == pat[d]) found = d;
            if (found < 0) ok = 1'b0;
            else begin
                bcd[4*i +: 4] = 4'(found);
                num += found * mul;
            end
            mul *= 10;
        end
        return ok;
    endfunction

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic observe(input int kind, input logic [23:0] val);
        ev_t e;
        total++;
        if (q.size() == 0 || q[0].kind != kind || q[0].at != cyc) begin
            bad++;
            $display("FAIL unexpected_%s: pulse at cycle %0d value %h, required no pulse here",
                     kname[kind], cyc, val);
        end else begin
            e = q.pop_front();
            if (val !== e.val) begin
                bad++;
                $display("FAIL value_%s: at cycle %0d got %h expected %h", kname[kind], cyc, val, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_%s: expected at cycle %0d value %h, did not occur",
                     kname[q[0].kind], q[0].at, q[0].val);
            void'(q.pop_front());
        end
        if (score_valid === 1'b1) observe(0, score_bcd);
        if (decode_err === 1'b1)  observe(1, score_bcd);
        if (new_high === 1'b1)    observe(2, high_bcd);
    end

    task automatic set_word(input logic [41:0] w);
        {hex5, hex4, hex3, hex2, hex1, hex0} = w;
        last_w = w;
    endtask

    // Hold a new word for len edges; optionally pulse clear_high in the
    // cycle where its compare happens (needs len >= S+3).
    task automatic drive_run(input logic [41:0] w, input int len, input bit clr);
        int          start;
        int          num;
        logic [23:0] bcd;
        @(negedge clk);
        set_word(w);
        start = cyc + 1;
        if (len >= S) begin
            if (dec_word(w, bcd, num)) begin
                q.push_back('{kind: 0, val: bcd, at: start + S});
                score_m = bcd;
                if (HIGH_EN && !clr && num > high_num) begin
                    high_m   = bcd;
                    high_num = num;
                    q.push_back('{kind: 2, val: bcd, at: start + S + 1});
                end
            end else begin
                q.push_back('{kind: 1, val: score_m, at: start + S});
            end
        end
        if (HIGH_EN && clr) begin
            high_m   = '0;
            high_num = 0;
        end
        for (int i = 1; i < len; i++) begin
            @(negedge clk);
            clear_high = clr && (cyc == start + S);
        end
        clear_high = 1'b0;
    endtask

    task automatic reset_then_blank(input int len);
        int start;
        @(negedge clk);
        reset = 1'b1;
        clear_high = 1'b0;
        set_word('1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_score_bcd", score_bcd, 24'h0);
        chk("rst_high_bcd", high_bcd, 24'h0);
        chk("rst_pulses", {21'h0, score_valid, decode_err, new_high}, 24'h0);
        score_m  = '0;
        high_m   = '0;
        high_num = 0;
        reset = 1'b0;
        start = cyc;
        q.push_back('{kind: 1, val: 24'h0, at: start + S});
        repeat (len - 1) @(negedge clk);
    endtask

    task automatic reset_mid_capture(input logic [41:0] w);
        int start;
        @(negedge clk);
        set_word(w);
        start = cyc + 1;
        while (cyc < start + S - 1) @(negedge clk);
        reset = 1'b1;
        set_word('1);
        reset_then_blank(10);
    endtask

    logic [41:0] w;
    int          len;
    int          pos;

    initial begin
        reset_then_blank(10);

        drive_run(word_of(123), S + 6, 1'b0);
        drive_run(word_of(99),  S + 4, 1'b0);
        drive_run(word_of(123), S + 4, 1'b0);

        for (int i = 0; i < 10; i++)
            drive_run(word_of((i % 2 == 0) ? 6 : 5), 3, 1'b0);
        drive_run(word_of(6), S + 4, 1'b0);

        drive_run(word_of(999999), S + 4, 1'b1);
        drive_run(word_of(1), S + 4, 1'b0);

        w = word_of(1);
        w[21 +: 7] = 7'h0A;
        drive_run(w, S + 4, 1'b0);

        for (int r = 0; r < 40; r++) begin
            w = word_of(int'($urandom_range(0, 999999)));
            if ($urandom_range(0, 5) == 0) begin
                pos = int'($urandom_range(0, 5));
                w[7*pos +: 7] = 7'($urandom_range(0, 127));
            end
            if (w == last_w) w[6:0] = ~w[6:0];
            if ($urandom_range(0, 7) == 0) drive_run(w, S + 3 + int'($urandom_range(0, 2)), 1'b1);
            else begin
                len = int'($urandom_range(1, S + 4));
                drive_run(w, len, 1'b0);
            end
        end

        reset_mid_capture(word_of(42));
        drive_run(word_of(7), S + 3, 1'b0);

        repeat (S + 4) @(negedge clk);
        while (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL leftover_%s: expected at cycle %0d value %h, did not occur",
                     kname[q[0].kind], q[0].at, q[0].val);
            void'(q.pop_front());
        end
        chk("final_score_bcd", score_bcd, score_m);
        chk("final_high_bcd", high_bcd, high_m);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seg_score_reader.md
SEG_SCORE_READER -- requirements
Module: seg_score_reader

Interface
REQ-001 The parameter STABLE_CYCLES SHALL default to 4 and sets the number of consecutive identical samples needed before a capture; the legal range is 2..255.
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the single clock; all logic is rising-edge.
REQ-003 The port reset SHALL be an input, 1 bit wide, and is a synchronous, active-high reset.
REQ-004 The ports hex0..hex5 SHALL be inputs, 7 bits each, carrying active-low seven-segment patterns; hex0 is the least significant digit and bit 6 is segment g.
REQ-005 The port clear_high SHALL be an input, 1 bit wide, that synchronously clears the high-score register.
REQ-006 The port score_bcd SHALL be an output, 24 bits wide, holding the last validly decoded score; digit 5 is in bits 23:20.
REQ-007 The port score_valid SHALL be an output, 1 bit wide, that pulses for one cycle when score_bcd updates.
REQ-008 The port decode_err SHALL be an output, 1 bit wide, that pulses for one cycle when a stable capture holds a non-decimal pattern.
REQ-009 The port high_bcd SHALL be an output, 24 bits wide, holding the highest score captured.
REQ-010 The port new_high SHALL be an output, 1 bit wide, that pulses for one cycle when high_bcd increases.

Function
REQ-011 The six inputs SHALL be sampled every cycle as a 42-bit word W, compared with the registered previous sample P, and then stored into P.
REQ-012 When W differs from P, the stability counter SHALL clear to 0 and the armed flag SHALL set; when W equals P, the counter SHALL increment and saturate at STABLE_CYCLES-1.
REQ-013 When armed is set and the counter equals STABLE_CYCLES-1, the FSM SHALL move from WAIT to CAPTURE and armed SHALL clear, so each distinct stable word is captured exactly once.
REQ-014 If the input changes at edge k and is then held, score_valid or decode_err SHALL assert in the cycle following edge k+STABLE_CYCLES.
REQ-015 The decoding SHALL accept only the patterns 40,79,24,30,19,12,02,78,00,18 (hex, for 0..9); any other pattern, including 7F (blank) and A-F, SHALL make the digit invalid.
REQ-016 In CAPTURE with all digits valid, the block SHALL load score_bcd, pulse score_valid, and go to COMPARE; with any digit invalid, it SHALL pulse decode_err, hold score_bcd, and return to WAIT.
REQ-017 In COMPARE, the block SHALL perform an unsigned BCD magnitude compare from digit 5 down to digit 0; if score_bcd is strictly greater than high_bcd, it SHALL load high_bcd and pulse new_high one cycle after score_valid; the FSM then returns to WAIT.
REQ-018 An equal score SHALL NOT update high_bcd or pulse new_high.
REQ-019 A clear_high SHALL set high_bcd to 0 on the next edge in any state; if it coincides with a COMPARE update, the clear SHALL win and new_high SHALL stay 0.
REQ-020 An input change during CAPTURE or COMPARE SHALL still update P, the counter, and armed per REQ-012, and a new capture SHALL NOT start until the FSM is back in WAIT.

Reset
REQ-021 On reset, the block SHALL set score_bcd, high_bcd, score_valid, decode_err, new_high and the counter to 0, P to all ones, armed to 1, and the FSM to WAIT.
REQ-022 A reset asserted mid-capture or mid-compare SHALL override all other activity, and no pulse SHALL occur in the cycle after reset.

Configuration
REQ-023 With the macro SEG_SCORE_READER_HIGH_EN defined, the high-score register, COMPARE state, clear_high and new_high SHALL be implemented.
REQ-024 Without SEG_SCORE_READER_HIGH_EN, high_bcd SHALL be tied to 0, new_high SHALL be tied to 0, clear_high SHALL be ignored, and CAPTURE SHALL return directly to WAIT; port widths SHALL be unchanged.

Structure
REQ-025 The shared package score_pkg SHALL hold NUM_DIGITS=6, the DIGIT_W=4 and SEG_W=7 width constants, the ten segment pattern constants, and the FSM state enum (WAIT, CAPTURE, COMPARE).
REQ-026 The per-digit decoding SHALL be one combinational sub-module, seg_to_bcd, with a 7-bit segment input and outputs digit[3:0] and valid, instantiated six times.

Verification
REQ-027 After reset, holding all inputs at 7F for 10 cycles SHALL produce exactly one decode_err pulse at cycle 5, with score_valid never asserting.
REQ-028 Applying digits 000123 and holding them SHALL produce score_valid 5 cycles after the change with score_bcd=000123, followed by new_high with high_bcd=000123.
REQ-029 Applying 000123, then 000099, then 000123 SHALL produce three score_valid pulses and exactly one new_high.
REQ-030 Toggling hex0 between 5 and 6 every 3 cycles for 30 cycles SHALL produce no pulses; then holding 6 SHALL produce one score_valid with score_bcd=000006.
REQ-031 Asserting clear_high in the COMPARE cycle for score 999999 SHALL leave high_bcd=0 with new_high never asserted; a later stable 000001 SHALL then pulse new_high.
REQ-032 Putting 0A in hex3 with the other digits valid SHALL pulse decode_err while score_bcd keeps its prior value; with the high-score macro undefined, high_bcd and new_high SHALL stay 0 for all of the above scenarios.
